// File: rtl/output_control_pkg.sv
// output_control_pkg: shared FSM state type and sizing constants for output_control
package output_control_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam int BLK_BYTES = 16;
    localparam int BYTE_W = 8;
    localparam int BUS_W = 32;
endpackage

// File: rtl/blk_shift128.sv
// blk_shift128: 128-bit load/shift register presenting the next byte of a block
//   clk, rst   : clock, asynchronous active-low reset
//   load, din  : capture a new block (bus0 in the top word)
//   shift      : advance to the following byte
//   nxt        : byte to register next (head of din on load, else head of the stored remainder)
//   MSB_FIRST  : 1 = byte [31:24] of each bus first, 0 = byte [7:0] first
module blk_shift128 import output_control_pkg::*; #(
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [4*BUS_W-1:0]   din,
    output logic [BYTE_W-1:0]    nxt
);
    localparam int W = 4 * BUS_W;
    logic [W-1:0] ord;
    logic [W-1:0] sr;
    // Byte-reverse each word when LSB-first so the head is always the top byte
    for (genvar g = 0; g < 4; g++) begin : g_word
        assign ord[g*BUS_W +: BUS_W] = (MSB_FIRST != 0) ? din[g*BUS_W +: BUS_W] :
            {din[g*BUS_W +: BYTE_W], din[g*BUS_W+BYTE_W +: BYTE_W],
             din[g*BUS_W+2*BYTE_W +: BYTE_W], din[g*BUS_W+3*BYTE_W +: BYTE_W]};
    end
    assign nxt = load ? ord[W-1 -: BYTE_W] : sr[W-1 -: BYTE_W];
    // Holds the bytes still to be presented, the next one at the top
    always_ff @(posedge clk or negedge rst)
        if (!rst) sr <= '0;
        else sr <= load ? {ord[W-BYTE_W-1:0], {BYTE_W{1'b0}}} :
                   shift ? {sr[W-BYTE_W-1:0], {BYTE_W{1'b0}}} : sr;
endmodule

// File: rtl/output_control.sv
// output_control: serializes 128-bit result blocks into a byte stream with one block of buffering
//   clk, rst (async, active-low)
//   I_bus0..I_bus3, blk_valid, blk_ready : block input, bus0 leaves first
//   byte_out, byte_valid, byte_last, out_ready : byte stream with backpressure
//   ovf : sticky, a block was dropped
//   OUTPUT_CONTROL_PARITY_EN : adds byte_par, odd parity bit registered with byte_out
module output_control import output_control_pkg::*; #(
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  I_bus0,
    input  logic [BUS_W-1:0]  I_bus1,
    input  logic [BUS_W-1:0]  I_bus2,
    input  logic [BUS_W-1:0]  I_bus3,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    output logic              byte_last,
`ifdef OUTPUT_CONTROL_PARITY_EN
    output logic              byte_par,
`endif
    output logic              ovf
);
    state_t             state;
    logic [3:0]         cnt;
    logic [4*BUS_W-1:0] hold;
    logic               hold_full;
    logic [BYTE_W-1:0]  nxt;
    logic               hs, last_hs, acc, load_bus, load_hold, to_hold, load, shift;
    assign blk_ready = !hold_full;
    assign hs        = byte_valid && out_ready;
    assign last_hs   = hs && cnt == 4'(BLK_BYTES - 1);
    assign acc       = blk_valid && blk_ready;
    // A block arriving as the last byte leaves with the holding slot empty goes straight to the shifter
    assign load_bus  = acc && (state == IDLE || last_hs);
    assign load_hold = last_hs && hold_full;
    assign to_hold   = acc && !load_bus;
    assign load      = load_bus || load_hold;
    assign shift     = hs && !last_hs;
    blk_shift128 #(.MSB_FIRST(MSB_FIRST)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (load_hold ? hold : {I_bus0, I_bus1, I_bus2, I_bus3}),
        .nxt   (nxt)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            ovf        <= 1'b0;
`ifdef OUTPUT_CONTROL_PARITY_EN
            byte_par   <= 1'b0;
`endif
        end else begin
            state      <= load ? SEND : last_hs ? IDLE : state;
            cnt        <= (load || last_hs) ? '0 : shift ? cnt + 4'd1 : cnt;
            hold       <= to_hold ? {I_bus0, I_bus1, I_bus2, I_bus3} : hold;
            hold_full  <= to_hold ? 1'b1 : load_hold ? 1'b0 : hold_full;
            byte_out   <= (load || shift) ? nxt : byte_out;
            byte_valid <= load ? 1'b1 : last_hs ? 1'b0 : byte_valid;
            byte_last  <= (load || last_hs) ? 1'b0 : shift ? cnt == 4'(BLK_BYTES - 2) : byte_last;
            ovf        <= ovf || (blk_valid && !blk_ready);
`ifdef OUTPUT_CONTROL_PARITY_EN
            byte_par   <= (load || shift) ? ~^nxt : byte_par;
`endif
        end
endmodule

// File: tb/tb_output_control.sv
// tb_output_control: directed self-checking bench for output_control (MSB-first and LSB-first instances)
module tb_output_control;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0;
    logic        blk_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        blk_ready, byte_valid, byte_last, ovf;
    logic [7:0]  byte_out;
    logic        lsb_ready, lsb_valid, lsb_last, lsb_ovf;
    logic [7:0]  lsb_byte;
`ifdef OUTPUT_CONTROL_PARITY_EN
    logic        byte_par, lsb_par;
`endif
    int total = 0;
    int bad = 0;
    logic [7:0] lsb_tab [16] = '{8'h33, 8'h22, 8'h11, 8'h00, 8'h77, 8'h66, 8'h55, 8'h44,
                                 8'hBB, 8'hAA, 8'h99, 8'h88, 8'hFF, 8'hEE, 8'hDD, 8'hCC};

    output_control #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .I_bus0(b0), .I_bus1(b1), .I_bus2(b2), .I_bus3(b3),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .out_ready(out_ready),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_last(byte_last),
`ifdef OUTPUT_CONTROL_PARITY_EN
        .byte_par(byte_par),
`endif
        .ovf(ovf)
    );
    output_control #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .I_bus0(b0), .I_bus1(b1), .I_bus2(b2), .I_bus3(b3),
        .blk_valid(blk_valid), .blk_ready(lsb_ready), .out_ready(out_ready),
        .byte_out(lsb_byte), .byte_valid(lsb_valid), .byte_last(lsb_last),
`ifdef OUTPUT_CONTROL_PARITY_EN
        .byte_par(lsb_par),
`endif
        .ovf(lsb_ovf)
    );

    always #5 clk = ~clk;

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        b0 = a; b1 = b; b2 = c; b3 = d;
        blk_valid = 1'b1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        total++; if ({byte_valid, byte_last, byte_out} !== 10'h0) begin bad++; $display("FAIL reset_outputs got %h exp 000", {byte_valid, byte_last, byte_out}); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL reset_blk_ready got %b exp 1", blk_ready); end
        total++; if ({lsb_ready, lsb_ovf, lsb_valid} !== 3'b100) begin bad++; $display("FAIL reset_lsb got %b exp 100", {lsb_ready, lsb_ovf, lsb_valid}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        total++; if ({byte_valid, blk_ready} !== 2'b01) begin bad++; $display("FAIL idle_after_reset got %b exp 01", {byte_valid, blk_ready}); end
    endtask

    task automatic test_basic;
        logic [9:0] got, exp;
        logic [9:0] lgot, lexp;
        offer(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
        total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got %b exp 1", blk_ready); end
        @(negedge clk);
        blk_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            got = {byte_valid, byte_last, byte_out};
            exp = {1'b1, i == 15, 8'(i * 17)};
            total++; if (got !== exp) begin bad++; $display("FAIL msb_byte%0d got %h exp %h", i, got, exp); end
            lgot = {lsb_valid, lsb_last, lsb_byte};
            lexp = {1'b1, i == 15, lsb_tab[i]};
            total++; if (lgot !== lexp) begin bad++; $display("FAIL lsb_byte%0d got %h exp %h", i, lgot, lexp); end
            @(negedge clk);
        end
        total++; if ({byte_valid, lsb_valid, blk_ready} !== 3'b001) begin bad++; $display("FAIL basic_end got %b exp 001", {byte_valid, lsb_valid, blk_ready}); end
    endtask

    task automatic test_stall;
        logic [9:0] got, exp;
        offer(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
        @(negedge clk);
        blk_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            got = {byte_valid, byte_last, byte_out};
            exp = {1'b1, k == 19, 8'((k < 3 ? k : k <= 7 ? 3 : k - 4) * 17)};
            total++; if (got !== exp) begin bad++; $display("FAIL stall_cycle%0d got %h exp %h", k, got, exp); end
            out_ready = !(k >= 3 && k <= 6);
            @(negedge clk);
        end
        out_ready = 1'b1;
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL stall_end got %b exp 0", byte_valid); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] got, exp;
        offer(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
        @(negedge clk);
        blk_valid = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            got = {byte_valid, byte_last, byte_valid ? byte_out : 8'h00};
            exp = {k < 32, k == 15 || k == 31, k < 16 ? 8'(k * 17) : k < 32 ? 8'hA5 : 8'h00};
            total++; if (got !== exp) begin bad++; $display("FAIL b2b_cycle%0d got %h exp %h", k, got, exp); end
            total++; if (blk_ready !== !(k >= 6 && k <= 15)) begin bad++; $display("FAIL b2b_ready%0d got %b exp %b", k, blk_ready, !(k >= 6 && k <= 15)); end
            total++; if (ovf !== (k >= 9)) begin bad++; $display("FAIL b2b_ovf%0d got %b exp %b", k, ovf, k >= 9); end
            if (k == 5) offer(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
            else if (k == 8) offer(32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A);
            else blk_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] got;
        offer(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
        @(negedge clk);
        blk_valid = 1'b0;
        for (int k = 0; k < 9; k++) @(negedge clk);
        total++; if (byte_out !== 8'h99) begin bad++; $display("FAIL mid_byte9 got %h exp 99", byte_out); end
        rst = 1'b0;
        #1;
        got = {byte_valid, byte_last, byte_out};
        total++; if (got !== 10'h0) begin bad++; $display("FAIL mid_reset_outputs got %h exp 000", got); end
        total++; if ({ovf, blk_ready} !== 2'b01) begin bad++; $display("FAIL mid_reset_flags got %b exp 01", {ovf, blk_ready}); end
`ifdef OUTPUT_CONTROL_PARITY_EN
        total++; if (byte_par !== 1'b0) begin bad++; $display("FAIL mid_reset_par got %b exp 0", byte_par); end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        offer(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
        @(negedge clk);
        blk_valid = 1'b0;
        got = {byte_valid, byte_last, byte_out};
        total++; if (got !== 10'h200) begin bad++; $display("FAIL post_reset_byte0 got %h exp 200", got); end
`ifdef OUTPUT_CONTROL_PARITY_EN
        total++; if (byte_par !== 1'b1) begin bad++; $display("FAIL post_reset_par got %b exp 1", byte_par); end
`endif
        @(negedge clk);
        got = {byte_valid, byte_last, byte_out};
        total++; if (got !== 10'h211) begin bad++; $display("FAIL post_reset_byte1 got %h exp 211", got); end
        for (int k = 0; k < 16; k++) @(negedge clk);
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL post_reset_end got %b exp 0", byte_valid); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
